// File: rtl/zint_pkg.sv
// Shared constants for the interrupt-source generator.
//   Raster defaults : H_TOTAL_DEF / V_TOTAL_DEF and the matching counter widths.
//   Config map      : ADDR_HINT, ADDR_VINTL, ADDR_VINTH (address 3 is ignored).
//   Reset values    : HINT_RST / VINT_RST, used for both staged and active copies.
package zint_pkg;

    localparam int H_TOTAL_DEF = 448;
    localparam int V_TOTAL_DEF = 320;
    localparam int HW_DEF      = 9;
    localparam int VW_DEF      = 9;

    localparam int HINT_W      = 8;
    localparam int VINT_W      = 9;

    localparam logic [1:0] ADDR_HINT  = 2'd0;
    localparam logic [1:0] ADDR_VINTL = 2'd1;
    localparam logic [1:0] ADDR_VINTH = 2'd2;

    localparam logic [HINT_W-1:0] HINT_RST = '0;
    localparam logic [VINT_W-1:0] VINT_RST = '0;

endpackage

// File: rtl/zint_src_raster_cnt.sv
// Raster position counters.
//   clk, res   : clock, asynchronous active-high reset
//   ce         : tick enable; both counters hold while low
//   hcnt       : horizontal position, 0..H_TOTAL-1
//   vcnt       : line number, 0..V_TOTAL-1
//   frame_tick : high on the ce tick where hcnt=0 and vcnt=0
module raster_cnt #(
    parameter int H_TOTAL = 448,
    parameter int V_TOTAL = 320,
    parameter int HW      = 9,
    parameter int VW      = 9
) (
    input  logic          clk,
    input  logic          res,
    input  logic          ce,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          frame_tick
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (ce) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
            end else begin
                hcnt <= hcnt + HW'(1);
            end
        end
    end

    assign frame_tick = ce && (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/zint_src.sv
// Interrupt-source generator feeding the Z80 interrupt controller.
// Produces one-clk start pulses; latching, masking and priority live downstream.
//   clk, res       : clock, asynchronous active-high reset
//   ce             : raster tick enable
//   cfg_we         : config write strobe (one clk)
//   cfg_addr       : 0 HINT[7:0], 1 VINT[7:0], 2 VINT[8] from data bit0, 3 ignored
//   cfg_data       : config write data
//   dma_act        : DMA busy, synchronous to clk
//   hcnt, vcnt     : raster position
//   int_start_frm  : frame INT pulse (line match on line VINT)
//   int_start_lin  : line INT pulse (every line at HINT*2)
//   int_start_dma  : DMA-end INT pulse (falling edge of dma_act)
module zint_src
    import zint_pkg::*;
#(
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF,
    parameter int HW      = HW_DEF,
    parameter int VW      = VW_DEF
) (
    input  logic          clk,
    input  logic          res,
    input  logic          ce,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_addr,
    input  logic [7:0]    cfg_data,
    input  logic          dma_act,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          int_start_frm,
    output logic          int_start_lin,
    output logic          int_start_dma
);

    logic              frame_tick;
    logic [HINT_W-1:0] hint_stg, hint_act, hint_eff;
    logic [VINT_W-1:0] vint_stg, vint_act, vint_eff;
    logic              hint_in_range, vint_in_range;
    logic              line_match, frame_match;
    logic              dma_act_r;

    raster_cnt #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .HW      (HW),
        .VW      (VW)
    ) u_raster_cnt (
        .clk        (clk),
        .res        (res),
        .ce         (ce),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .frame_tick (frame_tick)
    );

    // Writes only touch the staged copy. The active copy reloads on the frame
    // tick from the staged register as it stood before any same-cycle write.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            hint_stg <= HINT_RST;
            vint_stg <= VINT_RST;
            hint_act <= HINT_RST;
            vint_act <= VINT_RST;
        end else begin
            if (frame_tick) begin
                hint_act <= hint_stg;
                vint_act <= vint_stg;
            end
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_HINT:  hint_stg      <= cfg_data;
                    ADDR_VINTL: vint_stg[7:0] <= cfg_data;
                    ADDR_VINTH: vint_stg[8]   <= cfg_data[0];
                    default:    ;
                endcase
            end
        end
    end

    // On the frame tick itself the reload has not landed yet, so the compare
    // looks through to the staged values; line 0 of the new frame then already
    // uses the new positions.
    always_comb begin
        hint_eff      = frame_tick ? hint_stg : hint_act;
        vint_eff      = frame_tick ? vint_stg : vint_act;
        hint_in_range = 32'({hint_eff, 1'b0}) < 32'(H_TOTAL);
        vint_in_range = 32'(vint_eff) < 32'(V_TOTAL);
        line_match    = ce && !hcnt[0]
                        && (32'(hcnt[HW-1:1]) == 32'(hint_eff))
                        && hint_in_range;
        frame_match   = line_match
                        && (32'(vcnt) == 32'(vint_eff))
                        && vint_in_range;
    end

    // Pulses are re-evaluated every clk, so a ce gap can never stretch them.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            int_start_lin <= 1'b0;
            int_start_frm <= 1'b0;
            int_start_dma <= 1'b0;
            dma_act_r     <= 1'b0;
        end else begin
            int_start_lin <= line_match;
            int_start_frm <= frame_match;
            int_start_dma <= dma_act_r && !dma_act;
            dma_act_r     <= dma_act;
        end
    end

endmodule

// File: tb/tb_zint_src.sv
module tb_zint_src;

    localparam int HT    = 448;
    localparam int VT    = 8;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       res;
    logic       ce;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       dma_act;
    logic [8:0] hcnt;
    logic [8:0] vcnt;
    logic       int_start_frm;
    logic       int_start_lin;
    logic       int_start_dma;

    int total = 0;
    int bad   = 0;

    // reference model state
    int mh, mv;
    int stg_h, stg_v, act_h, act_v;
    bit mdma;
    bit e_lin, e_frm, e_dma;

    always #5 clk = ~clk;

    zint_src #(.H_TOTAL(HT), .V_TOTAL(VT), .HW(9), .VW(9)) dut (
        .clk           (clk),
        .res           (res),
        .ce            (ce),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .dma_act       (dma_act),
        .hcnt          (hcnt),
        .vcnt          (vcnt),
        .int_start_frm (int_start_frm),
        .int_start_lin (int_start_lin),
        .int_start_dma (int_start_dma)
    );

    task automatic model_reset();
        mh = 0; mv = 0;
        stg_h = 0; stg_v = 0; act_h = 0; act_v = 0;
        mdma = 1'b0;
        e_lin = 1'b0; e_frm = 1'b0; e_dma = 1'b0;
    endtask

    // Applies one clock of stimulus and advances the reference model.
    task automatic tick(input bit c, input bit we, input bit [1:0] a,
                        input bit [7:0] d, input bit dm);
        ce = c; cfg_we = we; cfg_addr = a; cfg_data = d; dma_act = dm;
        if (c && mh == 0 && mv == 0) begin
            act_h = stg_h;
            act_v = stg_v;
        end
        e_lin = c && (mh % 2 == 0) && (mh / 2 == act_h);
        e_frm = e_lin && (mv == act_v);
        e_dma = mdma && !dm;
        mdma  = dm;
        if (we) begin
            if (a == 2'd0)      stg_h = int'(d);
            else if (a == 2'd1) stg_v = (stg_v & 256) | int'(d);
            else if (a == 2'd2) stg_v = (stg_v & 255) | (d[0] ? 256 : 0);
        end
        if (c) begin
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv + 1) % VT;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res = 1'b1; ce = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 8'd0; dma_act = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({hcnt, vcnt, int_start_lin, int_start_frm, int_start_dma} !== 21'd0) begin
            bad++;
            $display("FAIL reset_state got h=%0d v=%0d lin=%b frm=%b dma=%b want all 0",
                     hcnt, vcnt, int_start_lin, int_start_frm, int_start_dma);
        end
        @(negedge clk);
        res = 1'b0;
        model_reset();
    endtask

    task automatic test_frame_default();
        int lin_n, frm_n, frm_first, frm_second;
        lin_n = 0; frm_n = 0; frm_first = -1; frm_second = -1;
        for (int i = 1; i <= FRAME + 3; i++) begin
            tick(1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
            total++;
            if (hcnt !== 9'(mh) || vcnt !== 9'(mv) || int_start_lin !== e_lin
                || int_start_frm !== e_frm || int_start_dma !== e_dma) begin
                bad++;
                $display("FAIL frame_default t=%0t got h=%0d v=%0d l=%b f=%b d=%b want h=%0d v=%0d l=%b f=%b d=%b",
                         $time, hcnt, vcnt, int_start_lin, int_start_frm, int_start_dma,
                         mh, mv, e_lin, e_frm, e_dma);
            end
            if (int_start_lin) lin_n++;
            if (int_start_frm) begin
                frm_n++;
                if (frm_n == 1) frm_first = i;
                if (frm_n == 2) frm_second = i;
            end
        end
        total++;
        if (frm_n != 2 || frm_first != 1 || frm_second != FRAME + 1 || lin_n != 9) begin
            bad++;
            $display("FAIL frame_default_pos got frm_n=%0d first=%0d second=%0d lin_n=%0d want 2 1 %0d 9",
                     frm_n, frm_first, frm_second, lin_n, FRAME + 1);
        end
    endtask

    task automatic test_cfg_midframe();
        bit [7:0] wd [3];
        int start_pos, n1, n_old;
        int old_frm, lin_n, frm_n, frm_v, pos_bad, wide;
        bit prev_lin, prev_frm;
        wd[0] = 8'h10; wd[1] = 8'h05; wd[2] = 8'h00;
        old_frm = 0; lin_n = 0; frm_n = 0; frm_v = -1; pos_bad = 0; wide = 0;
        prev_lin = 1'b0; prev_frm = 1'b0;
        start_pos = mv * HT + mh;
        n1 = 3 * HT - start_pos;
        n_old = FRAME - start_pos;
        for (int i = 0; i < n_old + FRAME; i++) begin
            if (i >= n1 && i < n1 + 3) tick(1'b1, 1'b1, 2'(i - n1), wd[i - n1], 1'b0);
            else                       tick(1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
            total++;
            if (hcnt !== 9'(mh) || vcnt !== 9'(mv) || int_start_lin !== e_lin
                || int_start_frm !== e_frm || int_start_dma !== e_dma) begin
                bad++;
                $display("FAIL cfg_midframe t=%0t got h=%0d v=%0d l=%b f=%b d=%b want h=%0d v=%0d l=%b f=%b d=%b",
                         $time, hcnt, vcnt, int_start_lin, int_start_frm, int_start_dma,
                         mh, mv, e_lin, e_frm, e_dma);
            end
            if ((prev_lin && int_start_lin) || (prev_frm && int_start_frm)) wide++;
            prev_lin = int_start_lin;
            prev_frm = int_start_frm;
            if (i < n_old) begin
                if (int_start_frm) old_frm++;
            end else begin
                if (int_start_lin) begin
                    lin_n++;
                    if (hcnt != 9'd33) pos_bad++;
                end
                if (int_start_frm) begin
                    frm_n++;
                    frm_v = int'(vcnt);
                end
            end
        end
        total++;
        if (old_frm != 0 || lin_n != VT || frm_n != 1 || frm_v != 5 || pos_bad != 0 || wide != 0) begin
            bad++;
            $display("FAIL cfg_midframe_sum got old_frm=%0d lin=%0d frm=%0d frm_v=%0d pos_bad=%0d wide=%0d want 0 %0d 1 5 0 0",
                     old_frm, lin_n, frm_n, frm_v, pos_bad, wide, VT);
        end
    endtask

    task automatic test_ce_gaps();
        int lin_n, stray;
        bit c, prev_c;
        lin_n = 0; stray = 0; prev_c = 1'b0;
        for (int i = 0; i < 6 * HT; i++) begin
            c = (i % 3 == 2);
            tick(c, 1'b0, 2'd0, 8'd0, 1'b0);
            total++;
            if (hcnt !== 9'(mh) || vcnt !== 9'(mv) || int_start_lin !== e_lin
                || int_start_frm !== e_frm || int_start_dma !== e_dma) begin
                bad++;
                $display("FAIL ce_gaps t=%0t got h=%0d v=%0d l=%b f=%b d=%b want h=%0d v=%0d l=%b f=%b d=%b",
                         $time, hcnt, vcnt, int_start_lin, int_start_frm, int_start_dma,
                         mh, mv, e_lin, e_frm, e_dma);
            end
            if (int_start_lin) begin
                lin_n++;
                if (!c) stray++;
            end
            prev_c = c;
        end
        total++;
        if (lin_n != 2 || stray != 0 || hcnt !== 9'd0 || vcnt !== 9'd2 || prev_c !== 1'b1) begin
            bad++;
            $display("FAIL ce_gaps_sum got lin=%0d stray=%0d h=%0d v=%0d want 2 0 0 2",
                     lin_n, stray, hcnt, vcnt);
        end
    endtask

    task automatic test_bounds();
        bit [7:0] hint_tab [5];
        int       vint_tab [5];
        int       lin_exp  [5];
        int       frm_exp  [5];
        int lin_n, frm_n;
        hint_tab[0] = 8'hF0; vint_tab[0] = 0;     lin_exp[0] = 0;  frm_exp[0] = 0;
        hint_tab[1] = 8'hE0; vint_tab[1] = 0;     lin_exp[1] = 0;  frm_exp[1] = 0;
        hint_tab[2] = 8'hDF; vint_tab[2] = 'h1FF; lin_exp[2] = VT; frm_exp[2] = 0;
        hint_tab[3] = 8'hDF; vint_tab[3] = VT;    lin_exp[3] = VT; frm_exp[3] = 0;
        hint_tab[4] = 8'h00; vint_tab[4] = VT-1;  lin_exp[4] = VT; frm_exp[4] = 1;
        tick(1'b1, 1'b1, 2'd0, hint_tab[0], 1'b0);
        tick(1'b1, 1'b1, 2'd1, 8'(vint_tab[0]), 1'b0);
        tick(1'b1, 1'b1, 2'd2, 8'(vint_tab[0] >> 8), 1'b0);
        while (!(mh == 0 && mv == 0)) begin
            tick(1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
            total++;
            if (hcnt !== 9'(mh) || vcnt !== 9'(mv) || int_start_lin !== e_lin
                || int_start_frm !== e_frm || int_start_dma !== e_dma) begin
                bad++;
                $display("FAIL bounds_lead t=%0t got h=%0d v=%0d l=%b f=%b want h=%0d v=%0d l=%b f=%b",
                         $time, hcnt, vcnt, int_start_lin, int_start_frm, mh, mv, e_lin, e_frm);
            end
        end
        for (int k = 0; k < 5; k++) begin
            lin_n = 0; frm_n = 0;
            for (int i = 0; i < FRAME; i++) begin
                if (k < 4 && i == 1)      tick(1'b1, 1'b1, 2'd0, hint_tab[k+1], 1'b0);
                else if (k < 4 && i == 2) tick(1'b1, 1'b1, 2'd1, 8'(vint_tab[k+1]), 1'b0);
                else if (k < 4 && i == 3) tick(1'b1, 1'b1, 2'd2, 8'(vint_tab[k+1] >> 8), 1'b0);
                else                      tick(1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
                total++;
                if (hcnt !== 9'(mh) || vcnt !== 9'(mv) || int_start_lin !== e_lin
                    || int_start_frm !== e_frm || int_start_dma !== e_dma) begin
                    bad++;
                    $display("FAIL bounds t=%0t cfg=%0d got h=%0d v=%0d l=%b f=%b want h=%0d v=%0d l=%b f=%b",
                             $time, k, hcnt, vcnt, int_start_lin, int_start_frm, mh, mv, e_lin, e_frm);
                end
                if (int_start_lin) lin_n++;
                if (int_start_frm) frm_n++;
            end
            total++;
            if (lin_n != lin_exp[k] || frm_n != frm_exp[k]) begin
                bad++;
                $display("FAIL bounds_count cfg=%0d hint=%0h vint=%0h got lin=%0d frm=%0d want lin=%0d frm=%0d",
                         k, hint_tab[k], vint_tab[k], lin_n, frm_n, lin_exp[k], frm_exp[k]);
            end
        end
    endtask

    task automatic test_dma();
        int n, idx;
        bit dm;
        n = 0; idx = -1;
        for (int i = 0; i < 15; i++) begin
            tick(1'b1, 1'b0, 2'd0, 8'd0, i < 10);
            total++;
            if (int_start_dma !== e_dma || int_start_lin !== e_lin || hcnt !== 9'(mh)) begin
                bad++;
                $display("FAIL dma_single i=%0d got dma=%b lin=%b h=%0d want dma=%b lin=%b h=%0d",
                         i, int_start_dma, int_start_lin, hcnt, e_dma, e_lin, mh);
            end
            if (int_start_dma) begin n++; idx = i; end
        end
        total++;
        if (n != 1 || idx != 10) begin
            bad++;
            $display("FAIL dma_single_sum got pulses=%0d at=%0d want 1 at 10", n, idx);
        end
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 2'd0, 8'd0, (i < 3) || (i >= 4 && i < 7));
            total++;
            if (int_start_dma !== e_dma) begin
                bad++;
                $display("FAIL dma_b2b i=%0d got dma=%b want %b", i, int_start_dma, e_dma);
            end
            if (int_start_dma) n++;
        end
        total++;
        if (n != 2) begin
            bad++;
            $display("FAIL dma_b2b_sum got pulses=%0d want 2", n);
        end
        dm = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) dm = !dm;
            tick($urandom_range(0, 1) == 1, 1'b0, 2'd0, 8'd0, dm);
            total++;
            if (hcnt !== 9'(mh) || vcnt !== 9'(mv) || int_start_lin !== e_lin
                || int_start_frm !== e_frm || int_start_dma !== e_dma) begin
                bad++;
                $display("FAIL dma_random t=%0t got h=%0d v=%0d l=%b f=%b d=%b want h=%0d v=%0d l=%b f=%b d=%b",
                         $time, hcnt, vcnt, int_start_lin, int_start_frm, int_start_dma,
                         mh, mv, e_lin, e_frm, e_dma);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lin_n, frm_n, dma_n;
        lin_n = 0; frm_n = 0; dma_n = 0;
        tick(1'b1, 1'b1, 2'd0, 8'h20, 1'b1);
        while (mh < 100) tick(1'b1, 1'b0, 2'd0, 8'd0, 1'b1);
        #2;
        res = 1'b1;
        #1;
        total++;
        if ({hcnt, vcnt, int_start_lin, int_start_frm, int_start_dma} !== 21'd0) begin
            bad++;
            $display("FAIL reset_async got h=%0d v=%0d lin=%b frm=%b dma=%b want all 0",
                     hcnt, vcnt, int_start_lin, int_start_frm, int_start_dma);
        end
        dma_act = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({hcnt, vcnt, int_start_lin, int_start_frm, int_start_dma} !== 21'd0) begin
            bad++;
            $display("FAIL reset_hold got h=%0d v=%0d lin=%b frm=%b dma=%b want all 0",
                     hcnt, vcnt, int_start_lin, int_start_frm, int_start_dma);
        end
        @(negedge clk);
        res = 1'b0;
        model_reset();
        for (int i = 0; i < 2 * HT; i++) begin
            tick(1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
            total++;
            if (hcnt !== 9'(mh) || vcnt !== 9'(mv) || int_start_lin !== e_lin
                || int_start_frm !== e_frm || int_start_dma !== e_dma) begin
                bad++;
                $display("FAIL reset_restart t=%0t got h=%0d v=%0d l=%b f=%b d=%b want h=%0d v=%0d l=%b f=%b d=%b",
                         $time, hcnt, vcnt, int_start_lin, int_start_frm, int_start_dma,
                         mh, mv, e_lin, e_frm, e_dma);
            end
            if (int_start_lin) lin_n++;
            if (int_start_frm) frm_n++;
            if (int_start_dma) dma_n++;
        end
        total++;
        if (lin_n != 2 || frm_n != 1 || dma_n != 0) begin
            bad++;
            $display("FAIL reset_restart_sum got lin=%0d frm=%0d dma=%0d want 2 1 0", lin_n, frm_n, dma_n);
        end
    endtask

    task automatic test_random();
        bit c, we, dm;
        bit [1:0] a;
        bit [7:0] d;
        dm = 1'b0;
        for (int i = 0; i < 9000; i++) begin
            c  = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 63) == 0);
            a  = 2'($urandom_range(0, 3));
            if (a == 2'd1)      d = 8'($urandom_range(0, VT + 1));
            else if (a == 2'd2) d = ($urandom_range(0, 7) == 0) ? 8'h01 : 8'hFE;
            else                d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) dm = !dm;
            tick(c, we, a, d, dm);
            total++;
            if (hcnt !== 9'(mh) || vcnt !== 9'(mv) || int_start_lin !== e_lin
                || int_start_frm !== e_frm || int_start_dma !== e_dma) begin
                bad++;
                $display("FAIL random t=%0t got h=%0d v=%0d l=%b f=%b d=%b want h=%0d v=%0d l=%b f=%b d=%b",
                         $time, hcnt, vcnt, int_start_lin, int_start_frm, int_start_dma,
                         mh, mv, e_lin, e_frm, e_dma);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_default();
        test_cfg_midframe();
        test_ce_gaps();
        test_bounds();
        test_dma();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
